// File: rtl/seven_seg_count_display.sv
// Four-digit multiplexed 7-segment display stage for a 4-bit up/down counter.
// Shows the value in decimal, direction and pause status, and flashes dp0 on value changes.
module seven_seg_count_display #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2000,
  parameter int unsigned FLASH_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  input  logic       dir,
  input  logic       stopped,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned SlotW  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FlashW = ($clog2(FLASH_FRAMES + 1) < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

  localparam logic [SlotW-1:0]  SlotLast  = SlotW'(REFRESH_DIV - 1);
  localparam logic [SlotW-1:0]  BlankEnd  = SlotW'(BLANK_CYCLES);
  localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_FRAMES);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegUp    = 7'b1000001;
  localparam logic [6:0] SegDown  = 7'b0100001;
  localparam logic [6:0] SegPause = 7'b0001100;

  typedef enum logic [1:0] {StDig0, StDig1, StDig2, StDig3} state_e;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Sync vector layout: {count[3:0], dir, stopped}
  logic [5:0]        sync1_q, sync2_q, sync_prev_q;
  logic [SlotW-1:0]  slot_q, slot_d;
  state_e            state_q, state_d;
  logic [3:0]        disp_count_q, disp_count_d;
  logic              disp_dir_q, disp_dir_d;
  logic              disp_stopped_q, disp_stopped_d;
  logic [FlashW-1:0] flash_q, flash_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        an_q, an_d;

  logic       slot_wrap;
  logic       dig0_entry;
  logic       sync_stable;
  logic       tens;
  logic [3:0] units;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_prev_q <= '0;
    end else begin
      sync1_q     <= {count, dir, stopped};
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  always_comb begin
    slot_wrap = (slot_q == SlotLast);
    slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
    state_d   = state_q;
    if (slot_wrap) begin
      unique case (state_q)
        StDig0: state_d = StDig1;
        StDig1: state_d = StDig2;
        StDig2: state_d = StDig3;
        StDig3: state_d = StDig0;
      endcase
    end
    dig0_entry = slot_wrap && (state_q == StDig3);
  end

  // Values are only taken at frame start, and only if the synced vector held for a clk.
  always_comb begin
    sync_stable    = (sync2_q == sync_prev_q);
    disp_count_d   = disp_count_q;
    disp_dir_d     = disp_dir_q;
    disp_stopped_d = disp_stopped_q;
    flash_d        = flash_q;
    if (dig0_entry) begin
      if (sync_stable && (sync2_q[5:2] != disp_count_q)) begin
        flash_d = FlashLoad;
      end else if (flash_q != '0) begin
        flash_d = flash_q - 1'b1;
      end
      if (sync_stable) begin
        disp_count_d   = sync2_q[5:2];
        disp_dir_d     = sync2_q[1];
        disp_stopped_d = sync2_q[0];
      end
    end
  end

  // Outputs are computed from next-state so they line up with the registered slot.
  always_comb begin
    tens  = (disp_count_d >= 4'd10);
    units = tens ? (disp_count_d - 4'd10) : disp_count_d;
    an_d  = 4'b1111;
    seg_d = SegBlank;
    dp_d  = 1'b1;
    if (slot_d >= BlankEnd) begin
      unique case (state_d)
        StDig0: begin
          an_d  = 4'b1110;
          seg_d = digit_seg(units);
          dp_d  = (flash_d == '0);
        end
        StDig1: begin
          an_d  = 4'b1101;
          seg_d = tens ? digit_seg(4'd1) : SegBlank;
        end
        StDig2: begin
          an_d  = 4'b1011;
          seg_d = disp_stopped_d ? SegPause : SegBlank;
        end
        StDig3: begin
          an_d  = 4'b0111;
          seg_d = disp_dir_d ? SegDown : SegUp;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q         <= '0;
      state_q        <= StDig0;
      disp_count_q   <= '0;
      disp_dir_q     <= 1'b0;
      disp_stopped_q <= 1'b0;
      flash_q        <= '0;
      seg_q          <= SegBlank;
      dp_q           <= 1'b1;
      an_q           <= 4'b1111;
    end else begin
      slot_q         <= slot_d;
      state_q        <= state_d;
      disp_count_q   <= disp_count_d;
      disp_dir_q     <= disp_dir_d;
      disp_stopped_q <= disp_stopped_d;
      flash_q        <= flash_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      an_q           <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_count_display.sv
// Self-checking bench for seven_seg_count_display with a cycle-indexed reference model.
module tb_seven_seg_count_display;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FF    = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       dir;
  logic       stopped;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int tests_run;
  int tests_failed;

  // Model: n = clk edges since reset release; displayed values and flash frames left.
  int         n;
  int         m_count;
  logic       m_dir;
  logic       m_stop;
  int         m_flash;
  logic [5:0] hist [0:3];

  seven_seg_count_display #(
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLANK),
    .FLASH_FRAMES(FF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .count  (count),
    .dir    (dir),
    .stopped(stopped),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Returns {an, seg, dp} expected right now.
  function automatic logic [11:0] expect_out();
    int slot;
    int dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    slot  = n % DIV;
    dig   = (n / DIV) % 4;
    e_an  = 4'b1111;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    if (slot >= BLANK) begin
      e_an = ~(4'b0001 << dig);
      case (dig)
        0: begin
          e_seg = digit_code(m_count % 10);
          e_dp  = (m_flash == 0);
        end
        1: e_seg = (m_count >= 10) ? digit_code(1) : 7'b1111111;
        2: e_seg = m_stop ? 7'b0001100 : 7'b1111111;
        default: e_seg = m_dir ? 7'b0100001 : 7'b1000001;
      endcase
    end
    return {e_an, e_seg, e_dp};
  endfunction

  task automatic model_clear();
    n       = 0;
    m_count = 0;
    m_dir   = 1'b0;
    m_stop  = 1'b0;
    m_flash = 0;
    for (int i = 0; i < 4; i++) hist[i] = 6'd0;
  endtask

  // Drive inputs, advance one clk, update the model, settle to sample time.
  task automatic step(input logic [3:0] c, input logic d, input logic s);
    count   = c;
    dir     = d;
    stopped = s;
    @(posedge clk);
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {c, d, s};
    n++;
    if (n % FRAME == 0) begin
      // Accept the value seen two edges ago if it had also been seen one edge before that.
      if (hist[2] == hist[3]) begin
        if (int'(hist[2][5:2]) != m_count) m_flash = FF;
        else if (m_flash > 0) m_flash--;
        m_count = int'(hist[2][5:2]);
        m_dir   = hist[2][1];
        m_stop  = hist[2][0];
      end else if (m_flash > 0) begin
        m_flash--;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    count   = 4'd0;
    dir     = 1'b0;
    stopped = 1'b0;
    apply_reset();
    tests_run++;
    if ({an, seg, dp} !== 12'b1111_1111111_1) begin
      tests_failed++;
      $display("FAIL reset_state got an=%b seg=%b dp=%b exp an=1111 seg=1111111 dp=1", an, seg, dp);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(4'd0, 1'b0, 1'b0);
      e = expect_out();
      tests_run++;
      if ({an, seg, dp} !== e) begin
        tests_failed++;
        $display("FAIL reset_scan n=%0d got %b_%b_%b exp %b_%b_%b", n, an, seg, dp,
                 e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_count_change();
    logic [11:0] e;
    int lows;
    lows = 0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      step(4'd13, 1'b0, 1'b0);
      e = expect_out();
      if (dp === 1'b0) lows++;
      tests_run++;
      if ({an, seg, dp} !== e) begin
        tests_failed++;
        $display("FAIL count_change n=%0d got %b_%b_%b exp %b_%b_%b", n, an, seg, dp,
                 e[11:8], e[7:1], e[0]);
      end
    end
    tests_run++;
    if (lows != FF * (DIV - BLANK)) begin
      tests_failed++;
      $display("FAIL flash_length got %0d dp-low cycles exp %0d", lows, FF * (DIV - BLANK));
    end
  endtask

  task automatic test_unstable();
    logic [11:0] e;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step((i % 2 == 0) ? 4'd5 : 4'd6, 1'b0, 1'b0);
      e = expect_out();
      tests_run++;
      if ({an, seg, dp} !== e) begin
        tests_failed++;
        $display("FAIL unstable n=%0d got %b_%b_%b exp %b_%b_%b", n, an, seg, dp,
                 e[11:8], e[7:1], e[0]);
      end
    end
    tests_run++;
    if (m_count != 13) begin
      tests_failed++;
      $display("FAIL unstable_hold model count %0d exp 13", m_count);
    end
    for (int i = 0; i < 5 * FRAME; i++) begin
      step(4'd6, 1'b0, 1'b0);
      e = expect_out();
      tests_run++;
      if ({an, seg, dp} !== e) begin
        tests_failed++;
        $display("FAIL settle n=%0d got %b_%b_%b exp %b_%b_%b", n, an, seg, dp,
                 e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_dir_stop();
    logic [11:0] e;
    int lows;
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(4'd6, 1'b1, 1'b1);
      e = expect_out();
      if (dp === 1'b0) lows++;
      tests_run++;
      if ({an, seg, dp} !== e) begin
        tests_failed++;
        $display("FAIL dir_stop n=%0d got %b_%b_%b exp %b_%b_%b", n, an, seg, dp,
                 e[11:8], e[7:1], e[0]);
      end
    end
    tests_run++;
    if (lows != 0) begin
      tests_failed++;
      $display("FAIL dir_stop_noflash got %0d dp-low cycles exp 0", lows);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] e;
    for (int i = 0; i < 6 * FRAME; i++) begin
      step((i < 3 * FRAME) ? 4'd0 : 4'd15, 1'b1, 1'b0);
      e = expect_out();
      tests_run++;
      if ({an, seg, dp} !== e) begin
        tests_failed++;
        $display("FAIL wrap n=%0d got %b_%b_%b exp %b_%b_%b", n, an, seg, dp,
                 e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [11:0] e;
    int guard;
    guard = 0;
    while (!(((n / DIV) % 4 == 2) && (n % DIV == 4)) && guard < 2 * FRAME) begin
      step(4'd9, 1'b1, 1'b1);
      guard++;
    end
    tests_run++;
    if (an !== 4'b1011) begin
      tests_failed++;
      $display("FAIL mid_slot_reach got an=%b exp 1011", an);
    end
    reset = 1'b1;
    model_clear();
    #1;
    tests_run++;
    if ({an, seg, dp} !== 12'b1111_1111111_1) begin
      tests_failed++;
      $display("FAIL reset_async got an=%b seg=%b dp=%b exp an=1111 seg=1111111 dp=1", an, seg, dp);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < DIV; i++) begin
      step(4'd9, 1'b1, 1'b1);
      e = expect_out();
      tests_run++;
      if ({an, seg, dp} !== e) begin
        tests_failed++;
        $display("FAIL post_reset n=%0d got %b_%b_%b exp %b_%b_%b", n, an, seg, dp,
                 e[11:8], e[7:1], e[0]);
      end
      if (n == BLANK) begin
        tests_run++;
        if (an !== 4'b1110) begin
          tests_failed++;
          $display("FAIL first_anode got an=%b exp 1110", an);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    logic [3:0]  c;
    logic [3:0]  c2;
    logic        d;
    logic        s;
    logic        toggle;
    int          len;
    for (int p = 0; p < 40; p++) begin
      c      = 4'($urandom_range(0, 15));
      c2     = 4'($urandom_range(0, 15));
      d      = 1'($urandom_range(0, 1));
      s      = 1'($urandom_range(0, 1));
      toggle = ($urandom_range(0, 3) == 0);
      len    = $urandom_range(1, 80);
      for (int i = 0; i < len; i++) begin
        step((toggle && (i % 2 == 1)) ? c2 : c, d, s);
        e = expect_out();
        tests_run++;
        if ({an, seg, dp} !== e) begin
          tests_failed++;
          $display("FAIL random n=%0d got %b_%b_%b exp %b_%b_%b", n, an, seg, dp,
                   e[11:8], e[7:1], e[0]);
        end
        tests_run++;
        if ($countones(~an) > 1) begin
          tests_failed++;
          $display("FAIL anode_onehot n=%0d got an=%b exp at most one low", n, an);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    count        = 4'd0;
    dir          = 1'b0;
    stopped      = 1'b0;
    model_clear();
    test_reset();
    test_count_change();
    test_unstable();
    test_dir_stop();
    test_wrap();
    test_reset_mid_slot();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
